dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: ADDR_W, 8, requester/memory address width.
REQ-002 Parameter: DATA_W, 8, requester/memory data width.
REQ-003 clk  input  1  system clock; all state updates on posedge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 p0_req / p1_req  input  1  access request, held until matching done.
REQ-006 p0_we / p1_we  input  1  1 = write, 0 = read; held with req.
REQ-007 p0_addr / p1_addr  input  ADDR_W  access address; held with req.
REQ-008 p0_wdata / p1_wdata  input  DATA_W  write data; held with req.
REQ-009 p0_done / p1_done  output  1  one-cycle completion pulse.
REQ-010 p0_rdata / p1_rdata  output  DATA_W  registered read data, valid while done=1.
REQ-011 p0_err / p1_err  output  1  range error flag, valid while done=1.
REQ-012 mem_address  output  ADDR_W  address to data memory.
REQ-013 mem_write  output  1  write strobe to data memory (memory samples on negedge clk).
REQ-014 mem_data_in  output  DATA_W  write data to data memory.
REQ-015 mem_data_out  input  DATA_W  combinational read data from data memory.
REQ-016 busy  output  1  high in any state other than IDLE.
REQ-017 contention_cnt  output  8  saturating count of cycles a requester waited.

Function
REQ-018 FSM states SHALL be IDLE, ACCESS, RESP; IDLE->ACCESS when any req=1; ACCESS->RESP unconditionally; RESP->IDLE unconditionally.
REQ-019 In IDLE, only p0_req -> grant port 0; only p1_req -> grant port 1; both -> grant the port not served last (round-robin pointer).
REQ-020 Grant selection and the granted port's addr/we/wdata SHALL be registered on the IDLE->ACCESS edge; later input changes SHALL not affect the access.
REQ-021 mem_address, mem_data_in SHALL be registered outputs, stable throughout ACCESS; mem_write=granted we during ACCESS only, 0 in all other states.
REQ-022 At end of ACCESS, mem_data_out SHALL be captured into the granted port's rdata register; write accesses SHALL return the written data.
REQ-023 In RESP, granted port's done=1 for exactly one cycle; other port done=0; latency req sampled (cycle N) -> done (cycle N+2).
REQ-024 Round-robin pointer SHALL update to the served port on entry to RESP.
REQ-025 A requester SHALL deassert req in the cycle after done, or keep it high to issue a back-to-back access (re-arbitrated in IDLE); minimum spacing between grants 3 cycles.
REQ-026 rdata/err registers SHALL hold value until the next completion on that port.
REQ-027 contention_cnt SHALL increment each cycle a req is high on a non-granted port while busy=1 or a simultaneous IDLE loss occurs; saturate at 255, no wrap.

Reset
REQ-028 Reset assertion mid-access SHALL abort it: state=IDLE, mem_write=0 immediately (asynchronous), no done issued.
REQ-029 Reset values: mem_address=0, mem_data_in=0, mem_write=0, done=0, rdata=0, err=0, busy=0, contention_cnt=0, pointer=port 1 served last (port 0 wins first tie).

Configuration
REQ-030 Macro DMEM_ARB_RANGE_CHECK_EN defined: access with addr[ADDR_W-1:5]!=0 SHALL still take ACCESS/RESP cycles but hold mem_write=0, return rdata=0 and err=1.
REQ-031 Macro undefined: no range check; upper address bits pass to memory (aliasing to addr[4:0]); err outputs tied 0.

Structure
REQ-032 Shared package dmem_arb_pkg SHALL hold the FSM state encoding (IDLE/ACCESS/RESP), port index constants, and MEM_DEPTH=32.
REQ-033 Sub-module rr_arb2 (2-way round-robin grant with pointer register) SHALL be instantiated; datapath muxing and FSM stay in dmem_arbiter.

Verification
REQ-034 p0 write addr 5 data 0xA5 -> mem_write=1 in ACCESS, p0_done at N+2; later p1 read addr 5 -> p1_rdata=0xA5, p1_err=0.
REQ-035 p0_req and p1_req high from reset, both reading addr 3 -> grants alternate p0,p1,p0; each done every 3 cycles; contention_cnt increments while waiting.
REQ-036 Reset asserted during ACCESS of p1 write addr 7 data 0x11 -> mem_write falls immediately, no p1_done, memory addr 7 retains reset value 7.
REQ-037 With DMEM_ARB_RANGE_CHECK_EN, p0 write addr 0x40 data 0xFF -> mem_write stays 0, p0_err=1, p0_rdata=0; without macro, memory addr 0 becomes 0xFF.
REQ-038 p1 continuous contention for 300 cycles -> contention_cnt saturates at 255.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arb_pkg
//  Description : Shared definitions for the two-port data-memory arbiter:
//                FSM state encoding, port index constants and memory depth.
//  Revision    : 1.0  initial release
// ============================================================================
package dmem_arb_pkg;

    // Number of words in the attached data memory. Address bits above
    // log2(MEM_DEPTH) are out of range.
    localparam int MEM_DEPTH = 32;
    localparam int c_MEM_AW  = $clog2(MEM_DEPTH);

    // Requester port indices.
    localparam logic c_PORT0 = 1'b0;
    localparam logic c_PORT1 = 1'b1;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter_if
//  Description : Bundle of the two requester ports and the data-memory port
//                of dmem_arbiter.
//                  slave  : arbiter view (takes requests, drives memory)
//                  master : environment view (requesters + memory)
//  Signals     : pN_req/we/addr/wdata  request side, held until pN_done
//                pN_done/rdata/err     one-cycle completion with result
//                mem_address/write/data_in  memory command (write on negedge)
//                mem_data_out          combinational memory read data
//  Revision    : 1.0  initial release
// ============================================================================
interface dmem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              p0_req;
    logic              p0_we;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata;
    logic              p0_done;
    logic [DATA_W-1:0] p0_rdata;
    logic              p0_err;

    logic              p1_req;
    logic              p1_we;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata;
    logic              p1_done;
    logic [DATA_W-1:0] p1_rdata;
    logic              p1_err;

    logic [ADDR_W-1:0] mem_address;
    logic              mem_write;
    logic [DATA_W-1:0] mem_data_in;
    logic [DATA_W-1:0] mem_data_out;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        output p0_done, p0_rdata, p0_err,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        output p1_done, p1_rdata, p1_err,
        output mem_address, mem_write, mem_data_in,
        input  mem_data_out
    );

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        input  p0_done, p0_rdata, p0_err,
        output p1_req, p1_we, p1_addr, p1_wdata,
        input  p1_done, p1_rdata, p1_err,
        input  mem_address, mem_write, mem_data_in,
        output mem_data_out
    );

endinterface
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb2
//  Description : Two-way round-robin grant. On a tie the port not served
//                last wins. The "served last" pointer resets to port 1 so
//                port 0 wins the first tie.
//  Ports       : clk, reset (async, active-high)
//                req0/req1   request inputs
//                update      load pointer with 'served' this cycle
//                served      index of the port just served
//                grant_valid any request present
//                grant       selected port index (combinational)
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    input  logic update,
    input  logic served,
    output logic grant_valid,
    output logic grant
);

    logic r_last;

    always_comb begin
        grant_valid = req0 | req1;
        grant       = c_PORT0;
        if (req0 && req1) begin
            grant = ~r_last;
        end else if (req1) begin
            grant = c_PORT1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last <= c_PORT1;
        end else if (update) begin
            r_last <= served;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter
//  Description : Two-port round-robin arbiter in front of a single-port data
//                memory. Each access runs IDLE -> ACCESS -> RESP; the grant,
//                address, direction and write data are latched when leaving
//                IDLE, so requester inputs may change afterwards.
//  Ports       : clk, reset (async, active-high)
//                bus             dmem_arbiter_if.slave (requesters + memory)
//                busy            high whenever the FSM is not IDLE
//                contention_cnt  saturating count of cycles a port waited
//  Config      : DMEM_ARB_RANGE_CHECK_EN - when defined, addresses with any
//                bit set above the memory index range complete with err=1,
//                rdata=0 and no write strobe. When undefined, upper address
//                bits pass straight through and err is always 0.
//  Revision    : 1.0  initial release
// ============================================================================
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    dmem_arbiter_if.slave    bus,
    output logic             busy,
    output logic [7:0]       contention_cnt
);

    arb_state_t        r_state;
    logic              r_gnt;
    logic              r_we;
    logic              r_acc_err;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_mem_write;
    logic              r_p0_done;
    logic              r_p1_done;
    logic [DATA_W-1:0] r_p0_rdata;
    logic [DATA_W-1:0] r_p1_rdata;
    logic              r_p0_err;
    logic              r_p1_err;
    logic [7:0]        r_cnt;

    logic              w_grant_valid;
    logic              w_grant;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic              w_sel_err;
    logic [DATA_W-1:0] w_resp_data;
    logic              w_contend;

    rr_arb2 u_rr_arb2 (
        .clk         (clk),
        .reset       (reset),
        .req0        (bus.p0_req),
        .req1        (bus.p1_req),
        .update      (r_state == ACCESS),
        .served      (r_gnt),
        .grant_valid (w_grant_valid),
        .grant       (w_grant)
    );

    // Request fields of the port that wins arbitration this cycle.
    assign w_sel_we    = (w_grant == c_PORT1) ? bus.p1_we    : bus.p0_we;
    assign w_sel_addr  = (w_grant == c_PORT1) ? bus.p1_addr  : bus.p0_addr;
    assign w_sel_wdata = (w_grant == c_PORT1) ? bus.p1_wdata : bus.p0_wdata;

`ifdef DMEM_ARB_RANGE_CHECK_EN
    assign w_sel_err = |w_sel_addr[ADDR_W-1:c_MEM_AW];
`else
    assign w_sel_err = 1'b0;
`endif

    // Writes echo their own data back; rejected accesses return zero.
    assign w_resp_data = r_acc_err ? '0 : (r_we ? r_wdata : bus.mem_data_out);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_gnt       <= c_PORT0;
            r_we        <= 1'b0;
            r_acc_err   <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_mem_write <= 1'b0;
            r_p0_done   <= 1'b0;
            r_p1_done   <= 1'b0;
            r_p0_rdata  <= '0;
            r_p1_rdata  <= '0;
            r_p0_err    <= 1'b0;
            r_p1_err    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_valid) begin
                        r_state     <= ACCESS;
                        r_gnt       <= w_grant;
                        r_we        <= w_sel_we;
                        r_acc_err   <= w_sel_err;
                        r_addr      <= w_sel_addr;
                        r_wdata     <= w_sel_wdata;
                        r_mem_write <= w_sel_we & ~w_sel_err;
                    end
                end
                ACCESS: begin
                    r_state     <= RESP;
                    r_mem_write <= 1'b0;
                    if (r_gnt == c_PORT0) begin
                        r_p0_done  <= 1'b1;
                        r_p0_rdata <= w_resp_data;
                        r_p0_err   <= r_acc_err;
                    end else begin
                        r_p1_done  <= 1'b1;
                        r_p1_rdata <= w_resp_data;
                        r_p1_err   <= r_acc_err;
                    end
                end
                RESP: begin
                    r_state   <= IDLE;
                    r_p0_done <= 1'b0;
                    r_p1_done <= 1'b0;
                end
                default: begin
                    r_state     <= IDLE;
                    r_mem_write <= 1'b0;
                    r_p0_done   <= 1'b0;
                    r_p1_done   <= 1'b0;
                end
            endcase
        end
    end

    // A port is waiting when it requests while the other port owns the
    // memory, or when it loses a simultaneous request in IDLE.
    assign w_contend = (busy && ((bus.p0_req && (r_gnt != c_PORT0)) ||
                                 (bus.p1_req && (r_gnt != c_PORT1)))) ||
                       (!busy && bus.p0_req && bus.p1_req);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= 8'd0;
        end else if (w_contend && (r_cnt != 8'hFF)) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    assign busy             = (r_state != IDLE);
    assign contention_cnt   = r_cnt;
    assign bus.mem_address  = r_addr;
    assign bus.mem_data_in  = r_wdata;
    assign bus.mem_write    = r_mem_write;
    assign bus.p0_done      = r_p0_done;
    assign bus.p1_done      = r_p1_done;
    assign bus.p0_rdata     = r_p0_rdata;
    assign bus.p1_rdata     = r_p1_rdata;
    assign bus.p0_err       = r_p0_err;
    assign bus.p1_err       = r_p1_err;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_arbiter
//  Description : Directed self-checking bench for dmem_arbiter with a
//                32-word data memory model (word i resets to value i,
//                written on negedge, indexed by address[4:0]).
//                Build with DMEM_ARB_RANGE_CHECK_EN defined to exercise the
//                range-check variant.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dmem_arbiter;

`ifdef DMEM_ARB_RANGE_CHECK_EN
    localparam bit c_RC = 1'b1;
`else
    localparam bit c_RC = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       busy;
    logic [7:0] contention_cnt;
    logic [7:0] mem [0:31];
    int         n_checks = 0;
    int         n_pass   = 0;

    dmem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    dmem_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus),
        .busy           (busy),
        .contention_cnt (contention_cnt)
    );

    always #5 clk = ~clk;

    // Data memory model.
    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 8'(i);
        forever begin
            @(negedge clk);
            if (bus.mem_write === 1'b1) mem[bus.mem_address[4:0]] <= bus.mem_data_in;
        end
    end
    assign bus.mem_data_out = mem[bus.mem_address[4:0]];

    task automatic idle_inputs;
        bus.p0_req = 1'b0; bus.p0_we = 1'b0; bus.p0_addr = 8'h00; bus.p0_wdata = 8'h00;
        bus.p1_req = 1'b0; bus.p1_we = 1'b0; bus.p1_addr = 8'h00; bus.p1_wdata = 8'h00;
    endtask

    // Pulse reset across one clock, releasing it on a negedge.
    task automatic pulse_reset;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        idle_inputs();
        @(negedge clk);
        n_checks++; if (bus.mem_address !== 8'h00) $display("FAIL rst_mem_address: got %h expected 00", bus.mem_address); else n_pass++;
        n_checks++; if (bus.mem_data_in !== 8'h00) $display("FAIL rst_mem_data_in: got %h expected 00", bus.mem_data_in); else n_pass++;
        n_checks++; if (bus.mem_write !== 1'b0) $display("FAIL rst_mem_write: got %b expected 0", bus.mem_write); else n_pass++;
        n_checks++; if ({bus.p0_done, bus.p1_done} !== 2'b00) $display("FAIL rst_done: got %b expected 00", {bus.p0_done, bus.p1_done}); else n_pass++;
        n_checks++; if ({bus.p0_rdata, bus.p1_rdata} !== 16'h0000) $display("FAIL rst_rdata: got %h expected 0000", {bus.p0_rdata, bus.p1_rdata}); else n_pass++;
        n_checks++; if ({bus.p0_err, bus.p1_err} !== 2'b00) $display("FAIL rst_err: got %b expected 00", {bus.p0_err, bus.p1_err}); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", busy); else n_pass++;
        n_checks++; if (contention_cnt !== 8'd0) $display("FAIL rst_cnt: got %0d expected 0", contention_cnt); else n_pass++;
        reset = 1'b0;
    endtask

    // p0 writes 0xA5 to address 5, then p1 reads it back.
    task automatic test_write_read;
        bus.p0_req = 1'b1; bus.p0_we = 1'b1; bus.p0_addr = 8'h05; bus.p0_wdata = 8'hA5;
        @(negedge clk); // ACCESS
        n_checks++; if (bus.mem_write !== 1'b1) $display("FAIL wr_mem_write: got %b expected 1", bus.mem_write); else n_pass++;
        n_checks++; if (bus.mem_address !== 8'h05) $display("FAIL wr_mem_address: got %h expected 05", bus.mem_address); else n_pass++;
        n_checks++; if (bus.mem_data_in !== 8'hA5) $display("FAIL wr_mem_data_in: got %h expected a5", bus.mem_data_in); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL wr_busy: got %b expected 1", busy); else n_pass++;
        n_checks++; if (bus.p0_done !== 1'b0) $display("FAIL wr_done_early: got %b expected 0", bus.p0_done); else n_pass++;
        // Inputs changing after the grant must not disturb the access.
        bus.p0_addr = 8'h09; bus.p0_wdata = 8'h3C; bus.p0_we = 1'b0;
        #1;
        n_checks++; if (bus.mem_address !== 8'h05) $display("FAIL wr_addr_held: got %h expected 05", bus.mem_address); else n_pass++;
        @(negedge clk); // RESP
        n_checks++; if (bus.p0_done !== 1'b1) $display("FAIL wr_p0_done: got %b expected 1", bus.p0_done); else n_pass++;
        n_checks++; if (bus.p1_done !== 1'b0) $display("FAIL wr_p1_done: got %b expected 0", bus.p1_done); else n_pass++;
        n_checks++; if (bus.mem_write !== 1'b0) $display("FAIL wr_mem_write_resp: got %b expected 0", bus.mem_write); else n_pass++;
        n_checks++; if (bus.p0_rdata !== 8'hA5) $display("FAIL wr_p0_rdata: got %h expected a5", bus.p0_rdata); else n_pass++;
        n_checks++; if (mem[5] !== 8'hA5) $display("FAIL wr_mem5: got %h expected a5", mem[5]); else n_pass++;
        n_checks++; if (mem[9] !== 8'h09) $display("FAIL wr_mem9: got %h expected 09", mem[9]); else n_pass++;
        bus.p0_req = 1'b0;
        @(negedge clk); // IDLE
        n_checks++; if (bus.p0_done !== 1'b0) $display("FAIL wr_done_one_cycle: got %b expected 0", bus.p0_done); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL wr_busy_idle: got %b expected 0", busy); else n_pass++;

        bus.p1_req = 1'b1; bus.p1_we = 1'b0; bus.p1_addr = 8'h05;
        @(negedge clk); // ACCESS
        n_checks++; if (bus.mem_write !== 1'b0) $display("FAIL rd_mem_write: got %b expected 0", bus.mem_write); else n_pass++;
        @(negedge clk); // RESP
        n_checks++; if (bus.p1_done !== 1'b1) $display("FAIL rd_p1_done: got %b expected 1", bus.p1_done); else n_pass++;
        n_checks++; if (bus.p1_rdata !== 8'hA5) $display("FAIL rd_p1_rdata: got %h expected a5", bus.p1_rdata); else n_pass++;
        n_checks++; if (bus.p1_err !== 1'b0) $display("FAIL rd_p1_err: got %b expected 0", bus.p1_err); else n_pass++;
        n_checks++; if (bus.p0_rdata !== 8'hA5) $display("FAIL rd_p0_rdata_hold: got %h expected a5", bus.p0_rdata); else n_pass++;
        bus.p1_req = 1'b0;
        @(negedge clk);
    endtask

    // Both ports request address 3 continuously from reset.
    task automatic test_round_robin;
        logic exp_d0, exp_d1;
        idle_inputs();
        bus.p0_req = 1'b1; bus.p0_addr = 8'h03;
        bus.p1_req = 1'b1; bus.p1_addr = 8'h03;
        pulse_reset();
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            exp_d0 = (k == 2) || (k == 8);
            exp_d1 = (k == 5);
            n_checks++; if (bus.p0_done !== exp_d0) $display("FAIL rr_p0_done k=%0d: got %b expected %b", k, bus.p0_done, exp_d0); else n_pass++;
            n_checks++; if (bus.p1_done !== exp_d1) $display("FAIL rr_p1_done k=%0d: got %b expected %b", k, bus.p1_done, exp_d1); else n_pass++;
            n_checks++; if (contention_cnt !== 8'(k)) $display("FAIL rr_cnt k=%0d: got %0d expected %0d", k, contention_cnt, k); else n_pass++;
        end
        n_checks++; if (bus.p0_rdata !== 8'h03) $display("FAIL rr_p0_rdata: got %h expected 03", bus.p0_rdata); else n_pass++;
        n_checks++; if (bus.p1_rdata !== 8'h03) $display("FAIL rr_p1_rdata: got %h expected 03", bus.p1_rdata); else n_pass++;
        idle_inputs();
    endtask

    // Reset lands in the middle of a p1 write to address 7.
    task automatic test_reset_abort;
        logic saw_done;
        pulse_reset();
        bus.p1_req = 1'b1; bus.p1_we = 1'b1; bus.p1_addr = 8'h07; bus.p1_wdata = 8'h11;
        @(posedge clk);
        #1;
        n_checks++; if (bus.mem_write !== 1'b1) $display("FAIL ab_write_started: got %b expected 1", bus.mem_write); else n_pass++;
        reset = 1'b1;
        #1;
        n_checks++; if (bus.mem_write !== 1'b0) $display("FAIL ab_mem_write: got %b expected 0", bus.mem_write); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL ab_busy: got %b expected 0", busy); else n_pass++;
        @(negedge clk);
        bus.p1_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        saw_done = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            saw_done = saw_done | bus.p1_done;
        end
        n_checks++; if (saw_done !== 1'b0) $display("FAIL ab_no_done: got %b expected 0", saw_done); else n_pass++;
        n_checks++; if (mem[7] !== 8'h07) $display("FAIL ab_mem7: got %h expected 07", mem[7]); else n_pass++;
        idle_inputs();
    endtask

    // p0 writes 0xFF to out-of-range address 0x40.
    task automatic test_range;
        logic [7:0] exp_rdata, exp_mem0;
        exp_rdata = c_RC ? 8'h00 : 8'hFF;
        exp_mem0  = c_RC ? 8'h00 : 8'hFF;
        bus.p0_req = 1'b1; bus.p0_we = 1'b1; bus.p0_addr = 8'h40; bus.p0_wdata = 8'hFF;
        @(negedge clk); // ACCESS
        n_checks++; if (bus.mem_write !== !c_RC) $display("FAIL rg_mem_write: got %b expected %b", bus.mem_write, !c_RC); else n_pass++;
        n_checks++; if (bus.mem_address !== 8'h40) $display("FAIL rg_mem_address: got %h expected 40", bus.mem_address); else n_pass++;
        @(negedge clk); // RESP
        n_checks++; if (bus.p0_done !== 1'b1) $display("FAIL rg_p0_done: got %b expected 1", bus.p0_done); else n_pass++;
        n_checks++; if (bus.p0_err !== c_RC) $display("FAIL rg_p0_err: got %b expected %b", bus.p0_err, c_RC); else n_pass++;
        n_checks++; if (bus.p0_rdata !== exp_rdata) $display("FAIL rg_p0_rdata: got %h expected %h", bus.p0_rdata, exp_rdata); else n_pass++;
        bus.p0_req = 1'b0;
        @(negedge clk);
        n_checks++; if (mem[0] !== exp_mem0) $display("FAIL rg_mem0: got %h expected %h", mem[0], exp_mem0); else n_pass++;
        idle_inputs();
    endtask

    // Continuous contention for 300 cycles saturates the counter.
    task automatic test_saturation;
        idle_inputs();
        bus.p0_req = 1'b1; bus.p0_addr = 8'h03;
        bus.p1_req = 1'b1; bus.p1_addr = 8'h03;
        pulse_reset();
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (k == 254 || k == 255 || k == 300) begin
                n_checks++;
                if (contention_cnt !== ((k < 255) ? 8'(k) : 8'd255))
                    $display("FAIL sat_cnt k=%0d: got %0d expected %0d", k, contention_cnt, (k < 255) ? k : 255);
                else
                    n_pass++;
            end
        end
        idle_inputs();
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_round_robin();
        test_reset_abort();
        test_range();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
